// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and default sizes.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero-index masking and ready gating.
// REGFILE_BYPASS_EN adds same-cycle forwarding from the write ports (highest port wins).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
`ifdef REGFILE_BYPASS_EN
  ,
  parameter int NWRITE = 2
`endif
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] mem_data,
`ifdef REGFILE_BYPASS_EN
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
`endif
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (ready && (raddr != ADDR_W'(RF_ZERO_IDX))) begin
      rdata = mem_data;
`ifdef REGFILE_BYPASS_EN
      // ascending scan so the highest-numbered matching port overrides
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr))
          rdata = wdata[j*DATA_W +: DATA_W];
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset hardware clear and ready flag.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
//
// state    | meaning
// RF_CLEAR | zeroing entries 1..2**ADDR_W-1, one per cycle; writes and reads blocked
// RF_RUN   | normal operation; ready = 1
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  rf_state_t         state;
  logic [ADDR_W-1:0] clr_idx;

  // Entry 0 is never written: reads of index 0 are masked to zero instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= ADDR_W'(1);
      ready   <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          mem[clr_idx] <= '0;
          if (clr_idx == '1) begin
            state <= RF_RUN;
            ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        RF_RUN: begin
          // later ports overwrite earlier ones on an address conflict
          for (int j = 0; j < NWRITE; j++) begin
            if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] != ADDR_W'(RF_ZERO_IDX)))
              mem[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
`ifdef REGFILE_BYPASS_EN
      ,
      .NWRITE (NWRITE)
`endif
    ) u_rd (
      .ready    (ready),
      .raddr    (raddr[i*ADDR_W +: ADDR_W]),
      .mem_data (mem[raddr[i*ADDR_W +: ADDR_W]]),
`ifdef REGFILE_BYPASS_EN
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
`endif
      .rdata    (rdata[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, either bypass build).
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  regfile_mp dut (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .raddr (raddr),
    .rdata (rdata),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic drive_wr(input logic [NW-1:0] en, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    wen = en;
    waddr = {a1, a0};
    wdata = {d1, d0};
  endtask

  task automatic count_to_ready(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ready && cnt < 100);
  endtask

  initial begin
    rst = 1'b1;
    raddr = '0;
    drive_wr(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    set_ra(0, 5'd7);
    @(negedge clk);
    check("clear_gate_rd", rd(0), 32'd0);
    check("clear_ready", 32'(ready), 32'd0);
    n = 1;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear_len", 32'(n), 32'd31);

    for (int i = 1; i < 32; i++) begin
      for (int p = 0; p < NR; p++) set_ra(p, 5'(i));
      #1;
      for (int p = 0; p < NR; p++) check($sformatf("zero_r%0d_p%0d", i, p), rd(p), 32'd0);
    end

    // basic write; same-cycle read shows bypass value or committed value
    @(negedge clk);
    drive_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    set_ra(0, 5'd5);
    set_ra(1, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr5_same_cycle", rd(0), 32'hDEADBEEF);
`else
    check("wr5_same_cycle", rd(0), 32'd0);
`endif
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0);
    #1;
    check("wr5_read", rd(0), 32'hDEADBEEF);
    check("r0_read", rd(1), 32'd0);

    // conflict: port 1 wins; and an independent dual write
    drive_wr(2'b11, 5'd9, 32'h1111_1111, 5'd9, 32'h2222_2222);
    @(negedge clk);
    drive_wr(2'b11, 5'd12, 32'h0C0C_0C0C, 5'd13, 32'h0D0D_0D0D);
    set_ra(2, 5'd9);
    #1;
    check("conflict_r9", rd(2), 32'h2222_2222);
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0);
    set_ra(0, 5'd12);
    set_ra(1, 5'd13);
    #1;
    check("dual_r12", rd(0), 32'h0C0C_0C0C);
    check("dual_r13", rd(1), 32'h0D0D_0D0D);

    // writes to index 0 are discarded
    drive_wr(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0);
    set_ra(0, 5'd0);
    set_ra(1, 5'd5);
    set_ra(2, 5'd9);
    set_ra(3, 5'd12);
    #1;
    check("zero_wr_r0", rd(0), 32'd0);
    check("zero_wr_r5", rd(1), 32'hDEADBEEF);
    check("zero_wr_r9", rd(2), 32'h2222_2222);
    check("zero_wr_r12", rd(3), 32'h0C0C_0C0C);

    // bypass: single writer, then conflicting writers, index 0 never forwarded
    drive_wr(2'b01, 5'd3, 32'hA5A5_A5A5, 5'd0, 32'd0);
    set_ra(2, 5'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_r3", rd(2), 32'hA5A5_A5A5);
`else
    check("byp_r3", rd(2), 32'd0);
`endif
    @(negedge clk);
    drive_wr(2'b11, 5'd3, 32'h3333_0000, 5'd3, 32'h3333_1111);
    set_ra(3, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_r3_prio", rd(2), 32'h3333_1111);
`else
    check("byp_r3_next", rd(2), 32'hA5A5_A5A5);
`endif
    check("byp_r0", rd(3), 32'd0);
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0);
    #1;
    check("r3_after_conflict", rd(2), 32'h3333_1111);

    // reset mid-run, then again mid-clear; writes during clear are dropped
    drive_wr(2'b10, 5'd0, 32'd0, 5'd7, 32'h1234_5678);
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0);
    set_ra(0, 5'd7);
    #1;
    check("r7_written", rd(0), 32'h1234_5678);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_run_ready", 32'(ready), 32'd0);
    check("rst_run_gate", rd(0), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_clear_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ra(1, 5'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 25) drive_wr(2'b01, 5'd2, 32'hBAD0_0002, 5'd0, 32'd0);
      if (n == 26) begin
        #1;
        check("clear_byp_gate", rd(1), 32'd0);
        drive_wr(2'b00, 0, 0, 0, 0);
      end
    end while (!ready && n < 100);
    check("reclear_len", 32'(n), 32'd31);
    set_ra(2, 5'd20);
    #1;
    check("r7_cleared", rd(0), 32'd0);
    check("r2_dropped", rd(1), 32'd0);
    check("r20_cleared", rd(2), 32'd0);

    // writes accepted again after the second clear
    drive_wr(2'b01, 5'd31, 32'hCAFE_F00D, 5'd0, 32'd0);
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0);
    set_ra(3, 5'd31);
    #1;
    check("r31_after_clear", rd(3), 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
